// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared constants for the pipelined CPU datapath
package cpu_pkg;
    localparam int DATA_W = 64;
    localparam int BR_SHIFT = 2;
    localparam logic OPC_CBZ = 1'b1;
    localparam logic OPC_BLT = 1'b0;
endpackage

// File: rtl/branch_target_gen.sv
// rtl/branch_target_gen.sv - combinational branch target: PC-relative sum or register target
module branch_target_gen
    import cpu_pkg::*;
#(
    parameter int W = DATA_W
) (
    input  logic [W-1:0] branch_offset,
    input  logic [W-1:0] curr_pc,
    input  logic [W-1:0] reg_target,
    input  logic         use_reg,
    output logic [W-1:0] target
);
    logic [W-1:0] br_shifted;
    logic [W-1:0] pc_branch;

    // Offset is in instruction words; bytes = words << 2, wrap is intended
    assign br_shifted = branch_offset << BR_SHIFT;
    assign pc_branch  = curr_pc + br_shifted;
    assign target     = use_reg ? reg_target : pc_branch;
endmodule

// File: rtl/branch_calcs.sv
// rtl/branch_calcs.sv - EX-stage branch resolution with registered target, PCSrc and flush
module branch_calcs
    import cpu_pkg::*;
#(
    parameter int DATA_W = cpu_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] branchSE_EX,
    input  logic [DATA_W-1:0] currPC_reg_EX,
    input  logic [DATA_W-1:0] resultALU,
    input  logic              uncondBr_EX,
    input  logic              branchReg_EX,
    input  logic              branch_EX,
    input  logic              zeroFlag,
    input  logic              negFlag,
    input  logic              opcode,
    output logic [DATA_W-1:0] calcBranch,
    output logic              PCSrc,
    output logic              IF_ID_flush
);
    logic [DATA_W-1:0] target;
    logic cbz;
    logic blt;
    logic cond;

    branch_target_gen #(.W(DATA_W)) u_target_gen (
        .branch_offset (branchSE_EX),
        .curr_pc       (currPC_reg_EX),
        .reg_target    (resultALU),
        .use_reg       (branchReg_EX),
        .target        (target)
    );

    assign cbz  = branch_EX & (opcode == OPC_CBZ) & zeroFlag;
    assign blt  = branch_EX & (opcode == OPC_BLT) & negFlag;
    assign cond = cbz | blt;

    // Only conditional branches request a flush; unconditional ones just redirect
    always_ff @(posedge clk) begin
        if (reset) begin
            calcBranch  <= '0;
            PCSrc       <= 1'b0;
            IF_ID_flush <= 1'b0;
        end else begin
            calcBranch  <= target;
            PCSrc       <= cond | uncondBr_EX;
            IF_ID_flush <= cond;
        end
    end
endmodule

// File: tb/tb_branch_calcs.sv
// tb/tb_branch_calcs.sv - scoreboard bench for branch_calcs
module tb_branch_calcs;
    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] branchSE_EX;
    logic [63:0] currPC_reg_EX;
    logic [63:0] resultALU;
    logic        uncondBr_EX;
    logic        branchReg_EX;
    logic        branch_EX;
    logic        zeroFlag;
    logic        negFlag;
    logic        opcode;
    logic [63:0] calcBranch;
    logic        PCSrc;
    logic        IF_ID_flush;

    typedef struct {
        logic [63:0] br;
        logic        pcsrc;
        logic        flush;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    branch_calcs dut (
        .clk           (clk),
        .reset         (reset),
        .branchSE_EX   (branchSE_EX),
        .currPC_reg_EX (currPC_reg_EX),
        .resultALU     (resultALU),
        .uncondBr_EX   (uncondBr_EX),
        .branchReg_EX  (branchReg_EX),
        .branch_EX     (branch_EX),
        .zeroFlag      (zeroFlag),
        .negFlag       (negFlag),
        .opcode        (opcode),
        .calcBranch    (calcBranch),
        .PCSrc         (PCSrc),
        .IF_ID_flush   (IF_ID_flush)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%h) expected %0d (0x%h)", tag, got, got, exp, exp);
        end
    endtask

    task automatic step(input string tag, input logic rst, input logic [63:0] se,
                        input logic [63:0] pc, input logic [63:0] alu, input logic u,
                        input logic breg, input logic b, input logic z, input logic n,
                        input logic op);
        exp_t e;
        exp_t got_e;
        logic c;
        @(negedge clk);
        reset = rst; branchSE_EX = se; currPC_reg_EX = pc; resultALU = alu;
        uncondBr_EX = u; branchReg_EX = breg; branch_EX = b;
        zeroFlag = z; negFlag = n; opcode = op;
        c = b && ((op && z) || (!op && n));
        if (rst) begin
            e.br = 64'd0; e.pcsrc = 1'b0; e.flush = 1'b0;
        end else begin
            e.br    = breg ? alu : pc + se * 64'd4;
            e.pcsrc = c || u;
            e.flush = c;
        end
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check({tag, ".sb_empty"}, 64'd1, 64'd0);
        end else begin
            got_e = sb.pop_front();
            check({tag, ".calcBranch"}, calcBranch, got_e.br);
            check({tag, ".PCSrc"}, {63'd0, PCSrc}, {63'd0, got_e.pcsrc});
            check({tag, ".flush"}, {63'd0, IF_ID_flush}, {63'd0, got_e.flush});
        end
    endtask

    initial begin
        // Reset, then the directed scenarios
        step("reset", 1, 400, 420, 32, 0, 0, 0, 0, 0, 0);
        step("none", 0, 400, 420, 32, 0, 0, 0, 0, 0, 0);
        step("uncond", 0, 400, 420, 32, 1, 0, 0, 0, 0, 0);
        step("uncond_drop", 0, 400, 420, 32, 0, 0, 0, 0, 0, 0);
        step("cbz_taken", 0, 400, 420, 32, 0, 0, 1, 1, 0, 1);
        step("cbz_not", 0, 400, 420, 32, 0, 0, 1, 0, 0, 1);
        step("blt_taken", 0, 400, 420, 32, 0, 0, 1, 0, 1, 0);
        step("blt_opc_cbz", 0, 400, 420, 32, 0, 0, 1, 0, 1, 1);
        step("br", 0, 400, 420, 32, 1, 1, 0, 0, 0, 0);
        step("masked", 0, 400, 420, 32, 0, 0, 0, 1, 1, 1);
        step("both", 0, 400, 420, 32, 1, 0, 1, 1, 0, 1);
        step("both_nc", 0, 400, 420, 32, 1, 0, 1, 0, 0, 1);
        step("breg_cond", 0, 400, 420, 77, 0, 1, 1, 1, 0, 1);
        step("neg_off", 0, -64'sd10, 420, 32, 1, 0, 0, 0, 0, 0);
        step("mid_reset", 1, -64'sd10, 420, 32, 1, 0, 1, 1, 0, 1);
        step("wrap", 0, 64'hC000_0000_0000_0001, 64'hFFFF_FFFF_FFFF_FFF0, 0, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 40; i++) begin
            step("rand", ($urandom_range(0, 15) == 0),
                 {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
                 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                 1'($urandom), 1'($urandom));
        end
        // Hard-coded spot values guard the model itself
        step("spot_2020", 0, 400, 420, 32, 0, 0, 0, 0, 0, 0);
        check("spot_2020.const", calcBranch, 64'd2020);
        step("spot_380", 0, -64'sd10, 420, 32, 1, 0, 0, 0, 0, 0);
        check("spot_380.const", calcBranch, 64'd380);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
